tx_msg_sequencer: RTL and testbench

Transmit-message sequencer for the QPSK modulator's info RAM. It owns the symbol read address and paces it at the baud rate, deriving one fetch every OS sample-rate enable ticks. It frames each message as start, send, optional inter-frame gap and repeat or stop. It sits between the host control registers and the info RAM / symbol mapper in tx_top, and replaces free-running address counting with an explicit start/stop/abort handshake.

---
 rtl/tx_msg_sequencer.sv | 154 +++++++++++++++
 tb/tb_tx_msg_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_msg_sequencer.sv
// tx_msg_sequencer: paces the info-RAM symbol address at the baud rate and frames messages.
// Each symbol lasts OS = 2**EXP_OS sample ticks (enb). A frame runs addresses 0..msg_long.
// In repeat mode, GAP_SYM idle symbols separate frames. i_stop ends the run gracefully at the
// end of the current frame; i_abort ends it on the next edge.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enb             sample-rate tick
//   i_start         start request (IDLE only); i_msg_long and i_repeat are latched with it
//   i_stop, i_abort graceful stop request / immediate stop
//   o_ram_addr      current symbol address     o_fetch      pulse on a new address
//   o_sym_valid     live symbol (SEND)         o_busy       SEND or GAP
//   o_done          pulse on normal completion o_frame_cnt  completed frames since start
module tx_msg_sequencer #(
  parameter int unsigned EXP_OS  = 2,
  parameter int unsigned RAM_EXP = 15,
  parameter int unsigned GAP_SYM = 4,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic               i_start,
  input  logic [RAM_EXP-1:0] i_msg_long,
  input  logic               i_repeat,
  input  logic               i_stop,
  input  logic               i_abort,
  output logic [RAM_EXP-1:0] o_ram_addr,
  output logic               o_fetch,
  output logic               o_sym_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam int unsigned OS    = 2 ** EXP_OS;
  localparam int unsigned GAP_W = (GAP_SYM > 0) ? $clog2(GAP_SYM + 1) : 1;
  localparam logic [EXP_OS-1:0] PhaseLast = EXP_OS'(OS - 1);
  localparam logic [GAP_W-1:0]  GapLoad   = GAP_W'((GAP_SYM > 0) ? GAP_SYM - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_t;

  state_t             r_state;
  logic [EXP_OS-1:0]  r_phase;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [RAM_EXP-1:0] r_msg_long;
  logic               r_repeat;
  logic               r_stop_pend;

  logic w_sym_end;
  logic w_stop;
  logic w_more;

  assign w_sym_end = enb && (r_phase == PhaseLast);
  // A stop raised in the same cycle as the frame end already counts.
  assign w_stop    = r_stop_pend | i_stop;
  // Wrap is decided by comparison, so a full-RAM message never relies on address carry.
  assign w_more    = (o_ram_addr < r_msg_long);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_phase     <= '0;
      r_gap_cnt   <= '0;
      r_msg_long  <= '0;
      r_repeat    <= 1'b0;
      r_stop_pend <= 1'b0;
      o_ram_addr  <= '0;
      o_fetch     <= 1'b0;
      o_sym_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_fetch <= 1'b0;
      o_done  <= 1'b0;
      if (r_state != StIdle && i_abort) begin
        // Abort wins over every other event; the frame count is kept.
        r_state     <= StIdle;
        r_phase     <= '0;
        o_ram_addr  <= '0;
        o_sym_valid <= 1'b0;
        o_busy      <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            o_ram_addr  <= '0;
            o_sym_valid <= 1'b0;
            o_busy      <= 1'b0;
            if (i_start) begin
              r_msg_long  <= i_msg_long;
              r_repeat    <= i_repeat;
              r_stop_pend <= 1'b0;
              r_phase     <= '0;
              o_frame_cnt <= '0;
              r_state     <= StSend;
              o_fetch     <= 1'b1;
              o_sym_valid <= 1'b1;
              o_busy      <= 1'b1;
            end
          end
          StSend: begin
            if (i_stop) r_stop_pend <= 1'b1;
            if (enb) r_phase <= r_phase + 1'b1;
            if (w_sym_end) begin
              if (w_more) begin
                o_ram_addr <= o_ram_addr + 1'b1;
                o_fetch    <= 1'b1;
              end else begin
                o_frame_cnt <= o_frame_cnt + 1'b1;
                o_ram_addr  <= '0;
                if (r_repeat && !w_stop && (GAP_SYM != 0)) begin
                  r_state     <= StGap;
                  r_gap_cnt   <= GapLoad;
                  o_sym_valid <= 1'b0;
                end else if (r_repeat && !w_stop) begin
                  o_fetch <= 1'b1;
                end else begin
                  r_state     <= StIdle;
                  o_sym_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
                end
              end
            end
          end
          StGap: begin
            if (i_stop) r_stop_pend <= 1'b1;
            if (enb) r_phase <= r_phase + 1'b1;
            if (w_sym_end) begin
              if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
              end else if (w_stop) begin
                r_state <= StIdle;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end else begin
                r_state     <= StSend;
                o_fetch     <= 1'b1;
                o_sym_valid <= 1'b1;
              end
            end
          end
          default: begin
            r_state     <= StIdle;
            o_ram_addr  <= '0;
            o_sym_valid <= 1'b0;
            o_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Directed bench for tx_msg_sequencer: u_dut has GAP_SYM=4 and RAM_EXP=15; u_dut0 has
// GAP_SYM=0 and RAM_EXP=4 so that back-to-back frames and a full-RAM wrap stay short.
// Every fetched address is compared against a scoreboard queue filled when a start is issued.
module tb_tx_msg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enb, i_start, i_start0, i_repeat, i_stop, i_abort;
  logic [14:0] i_msg_long;
  logic [3:0]  i_msg_long0;

  logic [14:0] o_ram_addr;
  logic        o_fetch, o_sym_valid, o_busy, o_done;
  logic [7:0]  o_frame_cnt;
  logic [3:0]  o_ram_addr0;
  logic        o_fetch0, o_sym_valid0, o_busy0, o_done0;
  logic [7:0]  o_frame_cnt0;

  tx_msg_sequencer #(.EXP_OS(2), .RAM_EXP(15), .GAP_SYM(4), .FRAME_W(8)) u_dut (
    .clk(clk), .rst(rst), .enb(enb), .i_start(i_start), .i_msg_long(i_msg_long),
    .i_repeat(i_repeat), .i_stop(i_stop), .i_abort(i_abort), .o_ram_addr(o_ram_addr),
    .o_fetch(o_fetch), .o_sym_valid(o_sym_valid), .o_busy(o_busy), .o_done(o_done),
    .o_frame_cnt(o_frame_cnt)
  );

  tx_msg_sequencer #(.EXP_OS(2), .RAM_EXP(4), .GAP_SYM(0), .FRAME_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .enb(enb), .i_start(i_start0), .i_msg_long(i_msg_long0),
    .i_repeat(i_repeat), .i_stop(i_stop), .i_abort(i_abort), .o_ram_addr(o_ram_addr0),
    .o_fetch(o_fetch0), .o_sym_valid(o_sym_valid0), .o_busy(o_busy0), .o_done(o_done0),
    .o_frame_cnt(o_frame_cnt0)
  );

  int n_checks = 0;
  int n_err    = 0;
  int enb_div  = 1;
  int e_cnt    = 0;

  logic [31:0] sb_q[$];
  logic [31:0] sb_q0[$];

  logic [31:0] lg_addr [0:199];
  logic        lg_fetch[0:199];
  logic        lg_val  [0:199];
  logic        lg_busy [0:199];
  logic        lg_done [0:199];
  logic [31:0] lg_fc   [0:199];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each fetch pops the next expected address.
  always @(negedge clk) begin
    if (o_fetch) begin
      check("fetch_while_valid", 32'(o_sym_valid), 32'd1);
      if (sb_q.size() == 0) check("fetch_unexpected", 32'(o_ram_addr), 32'hFFFF_FFFF);
      else check("fetch_addr", 32'(o_ram_addr), sb_q.pop_front());
    end
    if (o_fetch0) begin
      check("fetch0_while_valid", 32'(o_sym_valid0), 32'd1);
      if (sb_q0.size() == 0) check("fetch0_unexpected", 32'(o_ram_addr0), 32'hFFFF_FFFF);
      else check("fetch0_addr", 32'(o_ram_addr0), sb_q0.pop_front());
    end
  end

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    e_cnt = (e_cnt + 1) % enb_div;
    enb   = (e_cnt == 0);
  endtask

  // Runs from the start edge (k=1) until busy falls, logging outputs of the selected DUT.
  task automatic run(input int sel, input int max, input int stop_at, input int abort_at,
                     output int end_k);
    end_k = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      i_start  = 1'b0;
      i_start0 = 1'b0;
      i_stop   = (k == stop_at);
      i_abort  = (k == abort_at);
      if (sel == 0) begin
        lg_addr[k] = 32'(o_ram_addr);  lg_fetch[k] = o_fetch;  lg_val[k] = o_sym_valid;
        lg_busy[k] = o_busy;  lg_done[k] = o_done;  lg_fc[k] = 32'(o_frame_cnt);
      end else begin
        lg_addr[k] = 32'(o_ram_addr0); lg_fetch[k] = o_fetch0; lg_val[k] = o_sym_valid0;
        lg_busy[k] = o_busy0; lg_done[k] = o_done0; lg_fc[k] = 32'(o_frame_cnt0);
      end
      if (!lg_busy[k]) begin
        end_k = k;
        break;
      end
    end
    i_stop  = 1'b0;
    i_abort = 1'b0;
    if (end_k == 0) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset(input string tag, input int sel);
    if (sel == 0) begin
      check({tag, "_addr"},  32'(o_ram_addr),  32'd0);
      check({tag, "_fetch"}, 32'(o_fetch),     32'd0);
      check({tag, "_valid"}, 32'(o_sym_valid), 32'd0);
      check({tag, "_busy"},  32'(o_busy),      32'd0);
      check({tag, "_done"},  32'(o_done),      32'd0);
      check({tag, "_fc"},    32'(o_frame_cnt), 32'd0);
    end else begin
      check({tag, "_addr0"},  32'(o_ram_addr0),  32'd0);
      check({tag, "_fetch0"}, 32'(o_fetch0),     32'd0);
      check({tag, "_valid0"}, 32'(o_sym_valid0), 32'd0);
      check({tag, "_busy0"},  32'(o_busy0),      32'd0);
      check({tag, "_done0"},  32'(o_done0),      32'd0);
      check({tag, "_fc0"},    32'(o_frame_cnt0), 32'd0);
    end
  endtask

  function automatic int count_fetch(input int end_k);
    int n = 0;
    for (int k = 1; k <= end_k; k++) n += int'(lg_fetch[k]);
    return n;
  endfunction

  initial begin
    int end_k;
    int fk[$];
    int busy_seen;

    rst = 1'b1; enb = 1'b1; i_start = 1'b0; i_start0 = 1'b0; i_repeat = 1'b0;
    i_stop = 1'b0; i_abort = 1'b0; i_msg_long = '0; i_msg_long0 = '0;
    step();
    step();
    chk_reset("reset", 0);
    chk_reset("reset", 1);
    rst = 1'b0;
    step();

    // Single frame, enb every clk, msg_long=3.
    for (int a = 0; a < 4; a++) sb_q.push_back(32'(a));
    i_msg_long = 15'd3; i_repeat = 1'b0; i_start = 1'b1;
    run(0, 60, 0, 0, end_k);
    check("t1_latency_fetch", 32'(lg_fetch[1]), 32'd1);
    check("t1_latency_valid", 32'(lg_val[1]), 32'd1);
    check("t1_latency_busy", 32'(lg_busy[1]), 32'd1);
    for (int k = 1; k <= 16; k++) check("t1_addr_hold", lg_addr[k], 32'((k - 1) / 4));
    check("t1_done_clk", 32'(end_k), 32'd17);
    check("t1_done_pulse", 32'(lg_done[end_k]), 32'd1);
    check("t1_fetches", 32'(count_fetch(end_k)), 32'd4);
    check("t1_frame_cnt", lg_fc[end_k], 32'd1);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    step();
    check("t1_done_one_clk", 32'(o_done), 32'd0);

    // enb every 3rd clk, msg_long=1: 12-clk symbols.
    enb_div = 3; e_cnt = 0;
    sb_q.push_back(32'd0); sb_q.push_back(32'd1);
    i_msg_long = 15'd1; i_repeat = 1'b0; i_start = 1'b1;
    run(0, 100, 0, 0, end_k);
    for (int k = 1; k <= end_k; k++) if (lg_fetch[k]) fk.push_back(k);
    check("t2_fetches", 32'(fk.size()), 32'd2);
    if (fk.size() == 2) begin
      check("t2_fetch_spacing", 32'(fk[1] - fk[0]), 32'd12);
      check("t2_last_sym_len", 32'(end_k - fk[1]), 32'd12);
      check("t2_last_addr", lg_addr[end_k - 1], 32'd1);
    end
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    enb_div = 1; e_cnt = 0; enb = 1'b1;
    step();

    // Repeat with a 4-symbol gap; graceful stop in the second frame.
    for (int f = 0; f < 2; f++) for (int a = 0; a < 3; a++) sb_q.push_back(32'(a));
    i_msg_long = 15'd2; i_repeat = 1'b1; i_start = 1'b1;
    run(0, 120, 33, 0, end_k);
    for (int k = 1; k <= 12; k++) check("t3_valid_frame1", 32'(lg_val[k]), 32'd1);
    for (int k = 13; k <= 28; k++) check("t3_gap_invalid", 32'(lg_val[k]), 32'd0);
    check("t3_gap_busy", 32'(lg_busy[20]), 32'd1);
    check("t3_gap_addr", lg_addr[20], 32'd0);
    check("t3_fc_after_f1", lg_fc[13], 32'd1);
    check("t3_refetch", 32'(lg_fetch[29]), 32'd1);
    check("t3_refetch_addr", lg_addr[29], 32'd0);
    check("t3_fc_in_f2", lg_fc[40], 32'd1);
    check("t3_done_clk", 32'(end_k), 32'd41);
    check("t3_done_pulse", 32'(lg_done[end_k]), 32'd1);
    check("t3_frame_cnt", lg_fc[end_k], 32'd2);
    check("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    step();

    // GAP_SYM=0, full 16-entry RAM: 15 wraps to 0 with a fetch, then abort.
    for (int a = 0; a < 16; a++) sb_q0.push_back(32'(a));
    sb_q0.push_back(32'd0); sb_q0.push_back(32'd1);
    i_msg_long0 = 4'd15; i_repeat = 1'b1; i_start0 = 1'b1;
    run(1, 150, 0, 70, end_k);
    check("t4_last_addr", lg_addr[64], 32'd15);
    check("t4_wrap_addr", lg_addr[65], 32'd0);
    check("t4_wrap_fetch", 32'(lg_fetch[65]), 32'd1);
    check("t4_wrap_valid", 32'(lg_val[65]), 32'd1);
    check("t4_wrap_fc", lg_fc[65], 32'd1);
    check("t4_abort_clk", 32'(end_k), 32'd71);
    check("t4_abort_done", 32'(lg_done[end_k]), 32'd0);
    check("t4_sb_empty", 32'(sb_q0.size()), 32'd0);
    step();

    // Abort on an end-of-symbol tick in the second frame.
    sb_q.push_back(32'd0); sb_q.push_back(32'd1); sb_q.push_back(32'd0);
    i_msg_long = 15'd1; i_repeat = 1'b1; i_start = 1'b1;
    run(0, 100, 0, 28, end_k);
    check("t5_abort_clk", 32'(end_k), 32'd29);
    check("t5_abort_fetch", 32'(lg_fetch[end_k]), 32'd0);
    check("t5_abort_done", 32'(lg_done[end_k]), 32'd0);
    check("t5_abort_addr", lg_addr[end_k], 32'd0);
    check("t5_abort_valid", 32'(lg_val[end_k]), 32'd0);
    check("t5_fc_held", lg_fc[end_k], 32'd1);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    step();

    // msg_long=0: one-symbol frame.
    sb_q.push_back(32'd0);
    i_msg_long = 15'd0; i_repeat = 1'b0; i_start = 1'b1;
    run(0, 30, 0, 0, end_k);
    check("t6_done_clk", 32'(end_k), 32'd5);
    check("t6_fetches", 32'(count_fetch(end_k)), 32'd1);
    check("t6_done_pulse", 32'(lg_done[end_k]), 32'd1);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    step();

    // Reset mid-SEND with i_start held high.
    sb_q.push_back(32'd0); sb_q.push_back(32'd1);
    i_msg_long = 15'd3; i_repeat = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (4) step();
    check("t7_pre_reset_addr", 32'(o_ram_addr), 32'd1);
    rst = 1'b1; i_start = 1'b1;
    step();
    chk_reset("t7_rst", 0);
    rst = 1'b0; i_start = 1'b0;
    busy_seen = 0;
    repeat (8) begin
      step();
      busy_seen += int'(o_busy) + int'(o_fetch);
    end
    check("t7_no_restart", 32'(busy_seen), 32'd0);
    check("t7_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
